// File: rtl/riscv_proc_mul_tag_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_proc_mul_tag_pipe_pkg
//   Shared constants for the multiplier tag pipeline. These hold the values
//   that the legacy riscvConst.vh header supplied as `IMUL_STAGES and the
//   writeback tag width.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package riscv_proc_mul_tag_pipe_pkg;

   // Default multiplier pipeline depth (legacy `IMUL_STAGES); legal 1..8.
   localparam int unsigned IMUL_STAGES = 3;

   // Default width of the writeback register tag.
   localparam int unsigned MUL_TAG_W   = 5;

endpackage

// File: rtl/riscv_proc_mul_tag_pipe.sv
// -----------------------------------------------------------------------------
// riscv_proc_mul_tag_pipe
//   Tracks valid bits and destination tags of ops in flight through the
//   multiplier, with bubble-collapsing backpressure from writeback, a flush,
//   and a two-port scoreboard query for pending destination registers.
//
//   Ports:
//     clk            - clock, all state updates on rising edge
//     reset          - synchronous active-high reset
//     mul_fire       - issue request (qualified by mul_rdy, dropped on kill)
//     mul_waddr      - destination tag of the issued op
//     mul_rdy        - stage 0 can accept this cycle
//     mul_kill       - flush every in-flight op
//     wb_stall       - writeback cannot consume the result this cycle
//     mul_result_val - last stage holds a valid op
//     mul_result_tag - tag of the last-stage op
//     raddr1/raddr2  - scoreboard query tags
//     raddr1_busy/raddr2_busy - query tag is pending (tag 0 never busy)
//     busy           - any stage valid
// -----------------------------------------------------------------------------
module riscv_proc_mul_tag_pipe
   import riscv_proc_mul_tag_pipe_pkg::*;
#(
   parameter int unsigned STAGES = IMUL_STAGES,
   parameter int unsigned TAG_W  = MUL_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mul_fire,
   input  logic [TAG_W-1:0] mul_waddr,
   output logic             mul_rdy,
   input  logic             mul_kill,
   input  logic             wb_stall,
   output logic             mul_result_val,
   output logic [TAG_W-1:0] mul_result_tag,
   input  logic [TAG_W-1:0] raddr1,
   input  logic [TAG_W-1:0] raddr2,
   output logic             raddr1_busy,
   output logic             raddr2_busy,
   output logic             busy
);

   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0] r_val;
   logic [TAG_W-1:0]  r_tag [STAGES];

   logic [STAGES-1:0] w_ld;
   logic [STAGES-1:0] w_hit1;
   logic [STAGES-1:0] w_hit2;
   logic              w_accept;

   // w_ld[i]: slot i may take new content this cycle. Unrolling the
   // "empty or advancing" chain gives a flat form: slot i frees up when
   // writeback drains or any slot at or beyond i is empty (bubble collapse).
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      assign w_ld[g]   = ~wb_stall | ~(&r_val[STAGES-1:g]);
      assign w_hit1[g] = r_val[g] & (r_tag[g] == raddr1);
      assign w_hit2[g] = r_val[g] & (r_tag[g] == raddr2);
   end

   assign mul_rdy  = w_ld[0];
   assign w_accept = mul_fire & w_ld[0] & ~mul_kill;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_val <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_tag[i] <= '0;
         end
      end else if (mul_kill) begin
         // Flush drops valid bits only; stale tags are masked by valid.
         r_val <= '0;
      end else begin
         if (w_ld[0]) begin
            r_val[0] <= w_accept;
            if (w_accept) begin
               r_tag[0] <= mul_waddr;
            end
         end
         // Slot i loading means slot i-1 is advancing into it.
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (w_ld[i]) begin
               r_val[i] <= r_val[i-1];
               if (r_val[i-1]) begin
                  r_tag[i] <= r_tag[i-1];
               end
            end
         end
      end
   end

   assign mul_result_val = r_val[LAST];
   assign mul_result_tag = r_tag[LAST];
   assign busy           = |r_val;
   assign raddr1_busy    = (|w_hit1) & (raddr1 != '0);
   assign raddr2_busy    = (|w_hit2) & (raddr2 != '0);

endmodule

// File: tb/tb_riscv_proc_mul_tag_pipe.sv
// -----------------------------------------------------------------------------
// tb_riscv_proc_mul_tag_pipe
//   Directed bench for the multiplier tag pipeline: a 3-stage instance (a_*)
//   and a 1-stage instance (b_*). Inputs change on the falling edge; outputs
//   are checked 1 time unit later, so cycle k's inputs are sampled at the
//   rising edge that ends cycle k.
// -----------------------------------------------------------------------------
module tb_riscv_proc_mul_tag_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   logic       a_reset, a_fire, a_kill, a_stall;
   logic [4:0] a_waddr, a_r1, a_r2, a_tag;
   logic       a_rdy, a_val, a_b1, a_b2, a_busy;

   logic       b_reset, b_fire, b_kill, b_stall;
   logic [4:0] b_waddr, b_r1, b_r2, b_tag;
   logic       b_rdy, b_val, b_b1, b_b2, b_busy;

   riscv_proc_mul_tag_pipe #(.STAGES(3), .TAG_W(5)) u_dut_a (
      .clk(clk), .reset(a_reset), .mul_fire(a_fire), .mul_waddr(a_waddr),
      .mul_rdy(a_rdy), .mul_kill(a_kill), .wb_stall(a_stall),
      .mul_result_val(a_val), .mul_result_tag(a_tag),
      .raddr1(a_r1), .raddr2(a_r2), .raddr1_busy(a_b1), .raddr2_busy(a_b2),
      .busy(a_busy)
   );

   riscv_proc_mul_tag_pipe #(.STAGES(1), .TAG_W(5)) u_dut_b (
      .clk(clk), .reset(b_reset), .mul_fire(b_fire), .mul_waddr(b_waddr),
      .mul_rdy(b_rdy), .mul_kill(b_kill), .wb_stall(b_stall),
      .mul_result_val(b_val), .mul_result_tag(b_tag),
      .raddr1(b_r1), .raddr2(b_r2), .raddr1_busy(b_b1), .raddr2_busy(b_b2),
      .busy(b_busy)
   );

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         a_reset = 1'b1; a_fire = 1'b1; a_kill = 1'b1; a_waddr = 5'd3;
         b_reset = 1'b1; b_fire = 1'b1; b_kill = 1'b0; b_waddr = 5'd3;
      end
      @(negedge clk);
      a_reset = 1'b0; a_fire = 1'b0; a_kill = 1'b0; a_r1 = 5'd3; a_r2 = 5'd3;
      b_reset = 1'b0; b_fire = 1'b0; b_r1 = 5'd3; b_r2 = 5'd3;
      #1;
      vectors++; if (a_val !== 1'b0) begin miscompares++; $display("FAIL reset.a_val got %b want 0", a_val); end
      vectors++; if (a_tag !== 5'd0) begin miscompares++; $display("FAIL reset.a_tag got %0d want 0", a_tag); end
      vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset.a_busy got %b want 0", a_busy); end
      vectors++; if (a_b1 !== 1'b0 || a_b2 !== 1'b0) begin miscompares++; $display("FAIL reset.a_rbusy got %b%b want 00", a_b1, a_b2); end
      vectors++; if (a_rdy !== 1'b1) begin miscompares++; $display("FAIL reset.a_rdy got %b want 1", a_rdy); end
      vectors++; if (b_val !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL reset.b_val_busy got %b%b want 00", b_val, b_busy); end
      vectors++; if (b_tag !== 5'd0) begin miscompares++; $display("FAIL reset.b_tag got %0d want 0", b_tag); end
      vectors++; if (b_rdy !== 1'b1) begin miscompares++; $display("FAIL reset.b_rdy got %b want 1", b_rdy); end
   endtask

   // Fire tag 7 in cycle 0: result in cycle 3 only, raddr1=7 busy in 1..3.
   task automatic test_single();
      logic ev, eb;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         a_fire = (k == 0); a_waddr = 5'd7; a_r1 = 5'd7; a_r2 = 5'd6;
         #1;
         ev = (k == 3);
         eb = (k >= 1 && k <= 3);
         vectors++; if (a_val !== ev) begin miscompares++; $display("FAIL single.val c%0d got %b want %b", k, a_val, ev); end
         if (k == 3) begin
            vectors++; if (a_tag !== 5'd7) begin miscompares++; $display("FAIL single.tag c%0d got %0d want 7", k, a_tag); end
         end
         vectors++; if (a_b1 !== eb) begin miscompares++; $display("FAIL single.b1 c%0d got %b want %b", k, a_b1, eb); end
         vectors++; if (a_b2 !== 1'b0) begin miscompares++; $display("FAIL single.b2 c%0d got %b want 0", k, a_b2); end
         vectors++; if (a_busy !== eb) begin miscompares++; $display("FAIL single.busy c%0d got %b want %b", k, a_busy, eb); end
         vectors++; if (a_rdy !== 1'b1) begin miscompares++; $display("FAIL single.rdy c%0d got %b want 1", k, a_rdy); end
      end
   endtask

   // Tags 1,2,3 back-to-back, stall in cycles 3..4; fires of tag 20 while
   // the full pipe is stalled must be ignored.
   task automatic test_back_to_back();
      logic       ev, er, eb1, ebz;
      logic [4:0] et;
      logic [4:0] got[$];
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         a_fire  = (k < 5);
         a_waddr = (k < 3) ? 5'(k + 1) : 5'd20;
         a_stall = (k == 3 || k == 4);
         a_r1 = 5'd1; a_r2 = 5'd20;
         #1;
         ev  = (k >= 3 && k <= 7);
         et  = (k <= 5) ? 5'd1 : ((k == 6) ? 5'd2 : 5'd3);
         er  = !(k == 3 || k == 4);
         eb1 = (k >= 1 && k <= 5);
         ebz = (k >= 1 && k <= 7);
         vectors++; if (a_val !== ev) begin miscompares++; $display("FAIL b2b.val c%0d got %b want %b", k, a_val, ev); end
         if (ev) begin
            vectors++; if (a_tag !== et) begin miscompares++; $display("FAIL b2b.tag c%0d got %0d want %0d", k, a_tag, et); end
         end
         vectors++; if (a_rdy !== er) begin miscompares++; $display("FAIL b2b.rdy c%0d got %b want %b", k, a_rdy, er); end
         vectors++; if (a_b1 !== eb1) begin miscompares++; $display("FAIL b2b.b1 c%0d got %b want %b", k, a_b1, eb1); end
         vectors++; if (a_b2 !== 1'b0) begin miscompares++; $display("FAIL b2b.b2 c%0d got %b want 0", k, a_b2); end
         vectors++; if (a_busy !== ebz) begin miscompares++; $display("FAIL b2b.busy c%0d got %b want %b", k, a_busy, ebz); end
         if (a_val === 1'b1 && a_stall === 1'b0) got.push_back(a_tag);
      end
      a_fire = 1'b0; a_stall = 1'b0;
      vectors++;
      if (got.size() != 3) begin
         miscompares++; $display("FAIL b2b.count got %0d want 3", got.size());
      end else if (got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3) begin
         miscompares++; $display("FAIL b2b.order got %0d,%0d,%0d want 1,2,3", got[0], got[1], got[2]);
      end
   endtask

   // Reset asserted in cycle 2 of tag 11 in flight (with a fire of 12).
   task automatic test_reset_midop();
      logic eb;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         a_reset = (k == 2);
         a_fire  = (k == 0 || k == 2);
         a_waddr = (k == 0) ? 5'd11 : 5'd12;
         a_r1 = 5'd11; a_r2 = 5'd12;
         #1;
         eb = (k == 1 || k == 2);
         vectors++; if (a_val !== 1'b0) begin miscompares++; $display("FAIL rstmid.val c%0d got %b want 0", k, a_val); end
         vectors++; if (a_busy !== eb) begin miscompares++; $display("FAIL rstmid.busy c%0d got %b want %b", k, a_busy, eb); end
         vectors++; if (a_b1 !== eb) begin miscompares++; $display("FAIL rstmid.b1 c%0d got %b want %b", k, a_b1, eb); end
         vectors++; if (a_b2 !== 1'b0) begin miscompares++; $display("FAIL rstmid.b2 c%0d got %b want 0", k, a_b2); end
         if (k == 3) begin
            vectors++; if (a_tag !== 5'd0) begin miscompares++; $display("FAIL rstmid.tag c%0d got %0d want 0", k, a_tag); end
            vectors++; if (a_rdy !== 1'b1) begin miscompares++; $display("FAIL rstmid.rdy c%0d got %b want 1", k, a_rdy); end
         end
      end
      a_reset = 1'b0; a_fire = 1'b0;
   endtask

   task automatic test_kill();
      logic eb, ev;
      // Part 1: fire 4 at cycle 0, fire 5 with kill at cycle 2.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a_fire  = (k == 0 || k == 2);
         a_waddr = (k == 0) ? 5'd4 : 5'd5;
         a_kill  = (k == 2);
         a_r1 = 5'd4; a_r2 = 5'd5;
         #1;
         eb = (k == 1 || k == 2);
         vectors++; if (a_val !== 1'b0) begin miscompares++; $display("FAIL kill.val c%0d got %b want 0", k, a_val); end
         vectors++; if (a_busy !== eb) begin miscompares++; $display("FAIL kill.busy c%0d got %b want %b", k, a_busy, eb); end
         vectors++; if (a_b1 !== eb) begin miscompares++; $display("FAIL kill.b1 c%0d got %b want %b", k, a_b1, eb); end
         vectors++; if (a_b2 !== 1'b0) begin miscompares++; $display("FAIL kill.b2 c%0d got %b want 0", k, a_b2); end
         vectors++; if (a_rdy !== 1'b1) begin miscompares++; $display("FAIL kill.rdy c%0d got %b want 1", k, a_rdy); end
      end
      // Part 2: kill in the cycle tag 9 is at the output; it is still shown.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a_fire = (k == 0); a_waddr = 5'd9; a_kill = (k == 3); a_r1 = 5'd9;
         #1;
         ev = (k == 3);
         eb = (k >= 1 && k <= 3);
         vectors++; if (a_val !== ev) begin miscompares++; $display("FAIL killout.val c%0d got %b want %b", k, a_val, ev); end
         if (ev) begin
            vectors++; if (a_tag !== 5'd9) begin miscompares++; $display("FAIL killout.tag c%0d got %0d want 9", k, a_tag); end
         end
         vectors++; if (a_busy !== eb) begin miscompares++; $display("FAIL killout.busy c%0d got %b want %b", k, a_busy, eb); end
      end
      a_kill = 1'b0; a_fire = 1'b0;
   endtask

   // Tag 0 flows through but is never reported busy.
   task automatic test_tag_zero();
      logic eb, ev;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a_fire = (k == 0); a_waddr = 5'd0; a_r1 = 5'd0; a_r2 = 5'd0;
         #1;
         ev = (k == 3);
         eb = (k >= 1 && k <= 3);
         vectors++; if (a_val !== ev) begin miscompares++; $display("FAIL zero.val c%0d got %b want %b", k, a_val, ev); end
         if (ev) begin
            vectors++; if (a_tag !== 5'd0) begin miscompares++; $display("FAIL zero.tag c%0d got %0d want 0", k, a_tag); end
         end
         vectors++; if (a_b1 !== 1'b0 || a_b2 !== 1'b0) begin miscompares++; $display("FAIL zero.rbusy c%0d got %b%b want 00", k, a_b1, a_b2); end
         vectors++; if (a_busy !== eb) begin miscompares++; $display("FAIL zero.busy c%0d got %b want %b", k, a_busy, eb); end
      end
      a_fire = 1'b0;
   endtask

   // One-stage pipe, continuous fire, wb_stall toggling each cycle.
   task automatic test_stages1();
      logic       ev, er, eb;
      logic [4:0] et;
      int         accepts = 0;
      int         delivered = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         b_fire  = (k < 10);
         b_waddr = 5'(k + 1);
         b_stall = (k < 10) ? k[0] : 1'b0;
         b_r1 = 5'd1; b_r2 = 5'd0;
         #1;
         ev = (k >= 1 && k <= 10);
         et = k[0] ? 5'(k) : 5'(k - 1);
         er = !(k[0] && k < 10);
         eb = (k == 1 || k == 2);
         vectors++; if (b_val !== ev) begin miscompares++; $display("FAIL s1.val c%0d got %b want %b", k, b_val, ev); end
         if (ev) begin
            vectors++; if (b_tag !== et) begin miscompares++; $display("FAIL s1.tag c%0d got %0d want %0d", k, b_tag, et); end
         end
         vectors++; if (b_rdy !== er) begin miscompares++; $display("FAIL s1.rdy c%0d got %b want %b", k, b_rdy, er); end
         vectors++; if (b_busy !== ev) begin miscompares++; $display("FAIL s1.busy c%0d got %b want %b", k, b_busy, ev); end
         vectors++; if (b_b1 !== eb) begin miscompares++; $display("FAIL s1.b1 c%0d got %b want %b", k, b_b1, eb); end
         if (b_fire && er) accepts++;
         if (b_val === 1'b1 && b_stall === 1'b0) delivered++;
      end
      b_fire = 1'b0;
      vectors++;
      if (delivered != accepts || delivered != 5) begin
         miscompares++; $display("FAIL s1.balance got %0d delivered want %0d (accepted)", delivered, accepts);
      end
   endtask

   initial begin
      a_reset = 1'b1; a_fire = 1'b0; a_kill = 1'b0; a_stall = 1'b0;
      a_waddr = '0; a_r1 = '0; a_r2 = '0;
      b_reset = 1'b1; b_fire = 1'b0; b_kill = 1'b0; b_stall = 1'b0;
      b_waddr = '0; b_r1 = '0; b_r2 = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_midop();
      test_kill();
      test_tag_zero();
      test_stages1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
